// File: rtl/pulpemu_trace_pkg.sv
// Shared types and constants for the trace-buffer drain path.
package pulpemu_trace_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned LINE_WIDTH_DEF = 512;

  // Per-core record layout inside one captured trace line.
  localparam int unsigned CORE_REC_BITS       = 128;
  localparam int unsigned OFF_CYCLES_LO       = 0;
  localparam int unsigned OFF_CYCLES_HI_VMASK = 32;
  localparam int unsigned OFF_INSTR           = 64;
  localparam int unsigned OFF_PC              = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAP   = 3'd2,
    ST_SEND  = 3'd3,
    ST_FLUSH = 3'd4
  } drain_state_e;

  // Bit position of a field of a given core's record within a line.
  function automatic int unsigned core_field_bit(input int unsigned core,
                                                 input int unsigned off);
    return core * CORE_REC_BITS + off;
  endfunction

endpackage

// File: rtl/pulpemu_trace_drain_if.sv
// Valid/ready word stream from the trace drain toward the host link.
interface pulpemu_trace_drain_if;
  import pulpemu_trace_pkg::*;

  logic [WORD_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  out_last_o;

  modport master (
    output out_data_o,
    output out_valid_o,
    output out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_data_o,
    input  out_valid_o,
    input  out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/pulpemu_trace_serializer.sv
// Holds one trace line and emits it word 0 first on a valid/ready stream.
module pulpemu_trace_serializer
  import pulpemu_trace_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  send_i,
  input  logic                  last_line_i,
  pulpemu_trace_drain_if.master out_if,
  output logic                  line_done_o
);

  localparam int unsigned WPL    = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned WIDX_W = (WPL > 1) ? $clog2(WPL) : 1;

  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [WIDX_W-1:0]     word_q, word_d;
  logic [WORD_WIDTH-1:0] word_mux;
  logic                  accept;
  logic                  last_word;

  assign accept    = send_i & out_if.out_ready_i;
  assign last_word = (word_q == WIDX_W'(WPL - 1));

  // Line load and word advance on each accepted beat.
  always_comb begin
    line_d = line_q;
    word_d = word_q;
    if (load_i) begin
      line_d = line_i;
      word_d = '0;
    end else if (accept && !last_word) begin
      word_d = word_q + WIDX_W'(1);
    end
  end

  // Word select; an explicit compare loop keeps index widths exact.
  always_comb begin
    word_mux = '0;
    for (int unsigned i = 0; i < WPL; i++) begin
      if (word_q == WIDX_W'(i)) begin
        word_mux = line_q[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Line register and word index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      word_q <= '0;
    end else begin
      line_q <= line_d;
      word_q <= word_d;
    end
  end

  assign out_if.out_valid_o = send_i;
  assign out_if.out_data_o  = word_mux;
  assign out_if.out_last_o  = send_i & last_line_i & last_word;
  assign line_done_o        = accept & last_word;

  a_stall_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (out_if.out_valid_o && !out_if.out_ready_i)
      |=> (out_if.out_valid_o && $stable(out_if.out_data_o))
  );

endmodule

// File: rtl/pulpemu_trace_drain.sv
// Drains captured trace lines from the trace RAM read port as 32-bit words,
// then pulses trace_flushed_o so the capture side can restart.
module pulpemu_trace_drain
  import pulpemu_trace_pkg::*;
#(
  parameter int unsigned TRACE_BUFFER_DIM = 1024,
  parameter int unsigned LINE_WIDTH       = LINE_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH        = 16,
  localparam int unsigned ADDR_W          = $clog2(TRACE_BUFFER_DIM)
) (
  input  logic                  ref_clk_i,
  input  logic                  rst_ni,
  input  logic                  trace_wait_i,
  input  logic                  flush_req_i,
  input  logic [CNT_WIDTH-1:0]  wr_lines_i,
  output logic                  mem_en_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [LINE_WIDTH-1:0] mem_rdata_i,
  pulpemu_trace_drain_if.master out_if,
  output logic                  trace_flushed_o,
  output logic                  busy_o
);

  // One extra bit so a full buffer (N == depth) is representable.
  localparam int unsigned LCNT_W = ADDR_W + 1;

  drain_state_e      state_q, state_d;
  logic [LCNT_W-1:0] n_q, n_d;
  logic [LCNT_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LCNT_W-1:0] line_inc;
  logic              ser_load;
  logic              ser_send;
  logic              ser_last_line;
  logic              ser_line_done;

  assign line_inc = line_q + LCNT_W'(1);

  // Next-state logic; the RAM address is registered when entering RD so it
  // holds its last value whenever the read enable is low.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    line_d  = line_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trace_wait_i || flush_req_i) begin
          if (32'(wr_lines_i) > TRACE_BUFFER_DIM) begin
            n_d = LCNT_W'(TRACE_BUFFER_DIM);
          end else begin
            n_d = LCNT_W'(wr_lines_i);
          end
          line_d = '0;
          if (n_d == '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RD;
            addr_d  = '0;
          end
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_SEND;
      ST_SEND: begin
        if (ser_line_done) begin
          line_d = line_inc;
          if (line_inc == n_q) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RD;
            addr_d  = line_inc[ADDR_W-1:0];
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, line count and address registers.
  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_en_o        = (state_q == ST_RD);
  assign mem_addr_o      = addr_q;
  assign trace_flushed_o = (state_q == ST_FLUSH);
  assign busy_o          = (state_q != ST_IDLE);

  assign ser_load      = (state_q == ST_CAP);
  assign ser_send      = (state_q == ST_SEND);
  assign ser_last_line = (line_inc == n_q);

  pulpemu_trace_serializer #(
    .LINE_WIDTH (LINE_WIDTH)
  ) u_serializer (
    .clk_i       (ref_clk_i),
    .rst_ni      (rst_ni),
    .load_i      (ser_load),
    .line_i      (mem_rdata_i),
    .send_i      (ser_send),
    .last_line_i (ser_last_line),
    .out_if      (out_if),
    .line_done_o (ser_line_done)
  );

  a_flush_single : assert property (
    @(posedge ref_clk_i) disable iff (!rst_ni)
    trace_flushed_o |=> !trace_flushed_o
  );

  a_en_single : assert property (
    @(posedge ref_clk_i) disable iff (!rst_ni)
    mem_en_o |=> !mem_en_o
  );

endmodule

// File: tb/tb_pulpemu_trace_drain.sv
// Randomized self-checking bench for pulpemu_trace_drain.
module tb_pulpemu_trace_drain;

  localparam int DIM = 1024;
  localparam int LW  = 512;
  localparam int CW  = 16;
  localparam int AW  = 10;
  localparam int WPL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trace_wait = 1'b0;
  logic          flush_req = 1'b0;
  logic [CW-1:0] wr_lines = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_rdata = '0;
  logic          flushed;
  logic          busy;

  pulpemu_trace_drain_if sif ();

  pulpemu_trace_drain #(
    .TRACE_BUFFER_DIM (DIM),
    .LINE_WIDTH       (LW),
    .CNT_WIDTH        (CW)
  ) u_dut (
    .ref_clk_i       (clk),
    .rst_ni          (rst_n),
    .trace_wait_i    (trace_wait),
    .flush_req_i     (flush_req),
    .wr_lines_i      (wr_lines),
    .mem_en_o        (mem_en),
    .mem_addr_o      (mem_addr),
    .mem_rdata_i     (mem_rdata),
    .out_if          (sif),
    .trace_flushed_o (flushed),
    .busy_o          (busy)
  );

  initial forever #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] key = '0;
  int          ready_mode = 0;

  // Monitor state
  int          cyc = 0;
  logic [32:0] beats[$];
  int          reads[$];
  int          flush_cnt = 0;
  int          flush_cyc = -1;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  // Reference content: word w of line l is {l, w} scrambled by a per-test key.
  function automatic logic [31:0] word_of(input int l, input int w);
    return {l[15:0], w[15:0]} ^ key;
  endfunction

  function automatic logic [LW-1:0] line_of(input int l);
    logic [LW-1:0] r;
    r = '0;
    for (int w = 0; w < WPL; w++) r[w*32 +: 32] = word_of(l, w);
    return r;
  endfunction

  // Trace RAM model: data one cycle after the enable, junk otherwise.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= line_of(int'(mem_addr));
    else        mem_rdata <= {16{$urandom()}};
  end

  // Stream sink ready: always ready or ~30% duty.
  initial begin
    sif.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) sif.out_ready_i = 1'b1;
      else                 sif.out_ready_i = ($urandom_range(0, 99) < 30);
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (prev_stall && !(sif.out_valid_o && sif.out_data_o == prev_data))
        stall_viol = stall_viol + 1;
      prev_stall = sif.out_valid_o && !sif.out_ready_i;
      prev_data  = sif.out_data_o;
      if (sif.out_valid_o && sif.out_ready_i)
        beats.push_back({sif.out_last_o, sif.out_data_o});
      if (mem_en) reads.push_back(int'(mem_addr));
      if (flushed) begin
        flush_cnt = flush_cnt + 1;
        flush_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    beats.delete();
    reads.delete();
    flush_cnt  = 0;
    flush_cyc  = -1;
    stall_viol = 0;
  endtask

  // sel: 0 flush_req only, 1 trace_wait only, 2 both in the same cycle.
  task automatic pulse_req(input int sel, input int n, output int req_cyc);
    @(posedge clk);
    #1;
    wr_lines   = CW'(n);
    flush_req  = (sel != 1);
    trace_wait = (sel != 0);
    req_cyc    = cyc + 1;
    @(posedge clk);
    #1;
    flush_req  = 1'b0;
    trace_wait = 1'b0;
  endtask

  task automatic wait_flush(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (flush_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    timed_out = (flush_cnt == 0);
  endtask

  task automatic test_reset();
    #23;
    tests_run++; if (sif.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", sif.out_valid_o); end
    tests_run++; if (sif.out_data_o !== 32'h0) begin tests_failed++; $display("FAIL rst_data: got %h expected 0", sif.out_data_o); end
    tests_run++; if (sif.out_last_o !== 1'b0) begin tests_failed++; $display("FAIL rst_last: got %b expected 0", sif.out_last_o); end
    tests_run++; if (flushed !== 1'b0) begin tests_failed++; $display("FAIL rst_flushed: got %b expected 0", flushed); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
    tests_run++; if (mem_addr !== '0) begin tests_failed++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_three_lines();
    int req;
    bit to;
    logic [32:0] exp;
    key = '0;
    ready_mode = 0;
    clear_mon();
    pulse_req(0, 3, req);
    wait_flush(300, to);
    repeat (5) @(posedge clk);
    tests_run++; if (to) begin tests_failed++; $display("FAIL three_timeout: got no flush expected flush"); end
    tests_run++; if (beats.size() != 48) begin tests_failed++; $display("FAIL three_beats: got %0d expected 48", beats.size()); end
    for (int i = 0; i < 48 && i < beats.size(); i++) begin
      exp = {(i == 47), word_of(i / WPL, i % WPL)};
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("FAIL three_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++; if (flush_cyc - req != 55) begin tests_failed++; $display("FAIL three_flush_cycle: got %0d expected 55", flush_cyc - req); end
    tests_run++; if (flush_cnt != 1) begin tests_failed++; $display("FAIL three_flush_cnt: got %0d expected 1", flush_cnt); end
    tests_run++; if (reads.size() != 3) begin tests_failed++; $display("FAIL three_reads: got %0d expected 3", reads.size()); end
  endtask

  task automatic test_zero_lines();
    int req;
    clear_mon();
    pulse_req(0, 0, req);
    repeat (6) @(posedge clk);
    tests_run++; if (flush_cnt != 1) begin tests_failed++; $display("FAIL zero_flush_cnt: got %0d expected 1", flush_cnt); end
    tests_run++; if (flush_cyc - req != 1) begin tests_failed++; $display("FAIL zero_flush_cycle: got %0d expected 1", flush_cyc - req); end
    tests_run++; if (beats.size() != 0) begin tests_failed++; $display("FAIL zero_beats: got %0d expected 0", beats.size()); end
    tests_run++; if (reads.size() != 0) begin tests_failed++; $display("FAIL zero_reads: got %0d expected 0", reads.size()); end
  endtask

  task automatic test_backpressure();
    int req;
    bit to;
    int sel;
    logic [32:0] exp;
    key = $urandom();
    sel = $urandom_range(0, 2);
    ready_mode = 1;
    clear_mon();
    pulse_req(sel, 2, req);
    wait_flush(3000, to);
    ready_mode = 0;
    repeat (5) @(posedge clk);
    tests_run++; if (to) begin tests_failed++; $display("FAIL bp_timeout: got no flush expected flush"); end
    tests_run++; if (beats.size() != 32) begin tests_failed++; $display("FAIL bp_beats: got %0d expected 32", beats.size()); end
    for (int i = 0; i < 32 && i < beats.size(); i++) begin
      exp = {(i == 31), word_of(i / WPL, i % WPL)};
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("FAIL bp_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
    tests_run++; if (flush_cnt != 1) begin tests_failed++; $display("FAIL bp_flush_cnt: got %0d expected 1 (sel %0d)", flush_cnt, sel); end
    tests_run++; if (reads.size() != 2) begin tests_failed++; $display("FAIL bp_reads: got %0d expected 2", reads.size()); end
  endtask

  task automatic test_long_wait();
    bit to;
    int bad_rd;
    int bad_bt;
    logic [32:0] exp;
    key = $urandom();
    ready_mode = 0;
    clear_mon();
    @(posedge clk);
    #1;
    wr_lines   = CW'(1000);
    trace_wait = 1'b1;
    wait_flush(20000, to);
    #1 trace_wait = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++; if (to) begin tests_failed++; $display("FAIL long_timeout: got no flush expected flush"); end
    tests_run++; if (reads.size() != 1000) begin tests_failed++; $display("FAIL long_reads: got %0d expected 1000", reads.size()); end
    bad_rd = 0;
    for (int i = 0; i < reads.size(); i++) if (reads[i] != i) bad_rd++;
    tests_run++; if (bad_rd != 0) begin tests_failed++; $display("FAIL long_sweep: got %0d bad addresses expected 0", bad_rd); end
    tests_run++; if (beats.size() != 16000) begin tests_failed++; $display("FAIL long_beats: got %0d expected 16000", beats.size()); end
    bad_bt = 0;
    for (int i = 0; i < beats.size(); i++) begin
      exp = {(i == 15999), word_of(i / WPL, i % WPL)};
      if (beats[i] !== exp) bad_bt++;
    end
    tests_run++; if (bad_bt != 0) begin tests_failed++; $display("FAIL long_data: got %0d bad beats expected 0", bad_bt); end
    tests_run++; if (flush_cnt != 1) begin tests_failed++; $display("FAIL long_flush_cnt: got %0d expected 1", flush_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL long_retrigger: got busy %b expected 0", busy); end
  endtask

  task automatic test_clamp();
    int req;
    bit to;
    int bad_rd;
    int bad_bt;
    logic [32:0] exp;
    key = $urandom();
    ready_mode = 0;
    clear_mon();
    pulse_req(0, 1500, req);
    wait_flush(20000, to);
    repeat (5) @(posedge clk);
    tests_run++; if (to) begin tests_failed++; $display("FAIL clamp_timeout: got no flush expected flush"); end
    tests_run++; if (reads.size() != DIM) begin tests_failed++; $display("FAIL clamp_reads: got %0d expected %0d", reads.size(), DIM); end
    bad_rd = 0;
    for (int i = 0; i < reads.size(); i++) if (reads[i] != i) bad_rd++;
    tests_run++; if (bad_rd != 0) begin tests_failed++; $display("FAIL clamp_sweep: got %0d bad addresses expected 0", bad_rd); end
    tests_run++; if (beats.size() != DIM * WPL) begin tests_failed++; $display("FAIL clamp_beats: got %0d expected %0d", beats.size(), DIM * WPL); end
    bad_bt = 0;
    for (int i = 0; i < beats.size(); i++) begin
      exp = {(i == DIM * WPL - 1), word_of(i / WPL, i % WPL)};
      if (beats[i] !== exp) bad_bt++;
    end
    tests_run++; if (bad_bt != 0) begin tests_failed++; $display("FAIL clamp_data: got %0d bad beats expected 0", bad_bt); end
    if (beats.size() > 0) begin
      exp = {1'b1, word_of(DIM - 1, WPL - 1)};
      tests_run++;
      if (beats[beats.size()-1] !== exp) begin tests_failed++; $display("FAIL clamp_last: got %h expected %h", beats[beats.size()-1], exp); end
    end
  endtask

  task automatic test_reset_mid();
    int req;
    int n;
    bit to;
    logic [32:0] exp;
    key = $urandom();
    ready_mode = 0;
    clear_mon();
    pulse_req(0, 8, req);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(reads.size() >= 6 && sif.out_valid_o) && n < 400);
    tests_run++; if (n >= 400) begin tests_failed++; $display("FAIL rmid_reach_line5: got timeout expected SEND of line 5"); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (sif.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b expected 0", sif.out_valid_o); end
    tests_run++; if (sif.out_data_o !== 32'h0) begin tests_failed++; $display("FAIL rmid_data: got %h expected 0", sif.out_data_o); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    tests_run++; if (mem_en !== 1'b0 || mem_addr !== '0) begin tests_failed++; $display("FAIL rmid_mem: got en %b addr %h expected 0 0", mem_en, mem_addr); end
    repeat (3) @(posedge clk);
    tests_run++; if (flushed !== 1'b0 || flush_cnt != 0) begin tests_failed++; $display("FAIL rmid_no_flush: got %0d pulses expected 0", flush_cnt); end
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    pulse_req(1, 2, req);
    wait_flush(300, to);
    repeat (5) @(posedge clk);
    tests_run++; if (to) begin tests_failed++; $display("FAIL rmid_timeout: got no flush expected flush"); end
    tests_run++; if (reads.size() != 2 || (reads.size() > 0 && reads[0] != 0)) begin tests_failed++; $display("FAIL rmid_restart: got %0d reads expected 2 from line 0", reads.size()); end
    tests_run++; if (beats.size() != 32) begin tests_failed++; $display("FAIL rmid_beats: got %0d expected 32", beats.size()); end
    for (int i = 0; i < 32 && i < beats.size(); i++) begin
      exp = {(i == 31), word_of(i / WPL, i % WPL)};
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("FAIL rmid_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_three_lines();
    test_zero_lines();
    test_backpressure();
    test_backpressure();
    test_long_wait();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
